// File: rtl/sar_adc_ctrl.sv
// Successive-approximation controller for an N-bit ADC: MSB-first serial bit stream plus parallel result.
// Optional SAR_SAT_FLAG_EN adds a Sat output flagging all-zero / all-one results.
module sar_adc_ctrl #(
  parameter int N          = 10,
  parameter int SAMPLE_CYC = 2,
  parameter int SETTLE_CYC = 2
) (
  input  logic         CLK,
  input  logic         CLRbar,
  input  logic         Start,
  input  logic         CompIn,
  output logic         SampleHold,
  output logic [N-1:0] DacCode,
  output logic         SerOut,
  output logic         ShiftEn,
  output logic         Busy,
  output logic         Done,
`ifdef SAR_SAT_FLAG_EN
  output logic [N-1:0] Result,
  output logic         Sat
`else
  output logic [N-1:0] Result
`endif
);

  typedef enum logic [1:0] {IDLE, SAMPLE, TRIAL, DONE} state_e;

  localparam int MAXC = (SAMPLE_CYC > SETTLE_CYC) ? SAMPLE_CYC : SETTLE_CYC;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int IW   = $clog2(N);

  state_e         state_q;
  logic [CW-1:0]  cnt_q;
  logic [IW-1:0]  bitIdx_q;
  logic [N-1:0]   work_q;
  logic [N-1:0]   work_d;
  logic [N-1:0]   trial_d;
  logic           sampleHold_q;
  logic [N-1:0]   dacCode_q;
  logic           serOut_q;
  logic           shiftEn_q;
  logic           busy_q;
  logic           done_q;
  logic [N-1:0]   result_q;
  logic           sat_q;

  // Working word with the current bit decided, and the next trial code built on it.
  always_comb begin
    work_d           = work_q;
    work_d[bitIdx_q] = CompIn;
    trial_d          = work_d | (N'(1) << (bitIdx_q - IW'(1)));
  end

  always_ff @(posedge CLK or negedge CLRbar) begin
    if (!CLRbar) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bitIdx_q     <= '0;
      work_q       <= '0;
      sampleHold_q <= 1'b0;
      dacCode_q    <= '0;
      serOut_q     <= 1'b0;
      shiftEn_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      result_q     <= '0;
      sat_q        <= 1'b0;
    end else begin
      shiftEn_q <= 1'b0;
      serOut_q  <= 1'b0;
      done_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          busy_q    <= 1'b0;
          dacCode_q <= '0;
          if (Start) begin
            state_q      <= SAMPLE;
            busy_q       <= 1'b1;
            sampleHold_q <= 1'b1;
            cnt_q        <= '0;
          end
        end
        SAMPLE: begin
          if (cnt_q == CW'(SAMPLE_CYC - 1)) begin
            state_q      <= TRIAL;
            sampleHold_q <= 1'b0;
            cnt_q        <= '0;
            bitIdx_q     <= IW'(N - 1);
            work_q       <= '0;
            dacCode_q    <= N'(1) << (N - 1);
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        TRIAL: begin
          // The comparator is only looked at on the last settle cycle of each trial.
          if (cnt_q == CW'(SETTLE_CYC - 1)) begin
            cnt_q     <= '0;
            work_q    <= work_d;
            serOut_q  <= CompIn;
            shiftEn_q <= 1'b1;
            if (bitIdx_q == '0) begin
              state_q   <= DONE;
              dacCode_q <= '0;
              done_q    <= 1'b1;
              busy_q    <= 1'b0;
              result_q  <= work_d;
              sat_q     <= (work_d == '0) || (&work_d);
            end else begin
              bitIdx_q  <= bitIdx_q - IW'(1);
              dacCode_q <= trial_d;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign SampleHold = sampleHold_q;
  assign DacCode    = dacCode_q;
  assign SerOut     = serOut_q;
  assign ShiftEn    = shiftEn_q;
  assign Busy       = busy_q;
  assign Done       = done_q;
  assign Result     = result_q;

`ifdef SAR_SAT_FLAG_EN
  assign Sat = sat_q;
`else
  logic unusedSat;
  assign unusedSat = sat_q;
`endif

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Directed testbench for sar_adc_ctrl: vector table of comparator input codes plus
// hand sequences for Start-while-busy, held Start, mid-conversion reset and a slow-settle build.
module tb_sar_adc_ctrl;

  logic       clk;
  logic       clrN;
  logic       start;
  logic       compIn;
  logic [9:0] vinCode;
  logic       sampleHold;
  logic [9:0] dacCode;
  logic       serOut;
  logic       shiftEn;
  logic       busy;
  logic       done;
  logic [9:0] result;
  logic       sat;

  logic       start2;
  logic       compIn2;
  logic [9:0] vinCode2;
  logic       sampleHold2;
  logic [9:0] dacCode2;
  logic       serOut2;
  logic       shiftEn2;
  logic       busy2;
  logic       done2;
  logic [9:0] result2;
  logic       sat2;

  int nErr;
  int nChecks;

  // Ideal comparator: 1 when the input code is at or above the DAC trial code.
  assign compIn  = (vinCode >= dacCode);
  assign compIn2 = (vinCode2 >= dacCode2);

  sar_adc_ctrl dut (
    .CLK       (clk),
    .CLRbar    (clrN),
    .Start     (start),
    .CompIn    (compIn),
    .SampleHold(sampleHold),
    .DacCode   (dacCode),
    .SerOut    (serOut),
    .ShiftEn   (shiftEn),
    .Busy      (busy),
    .Done      (done),
`ifdef SAR_SAT_FLAG_EN
    .Result    (result),
    .Sat       (sat)
`else
    .Result    (result)
`endif
  );

  sar_adc_ctrl #(.N(10), .SAMPLE_CYC(1), .SETTLE_CYC(3)) dut2 (
    .CLK       (clk),
    .CLRbar    (clrN),
    .Start     (start2),
    .CompIn    (compIn2),
    .SampleHold(sampleHold2),
    .DacCode   (dacCode2),
    .SerOut    (serOut2),
    .ShiftEn   (shiftEn2),
    .Busy      (busy2),
    .Done      (done2),
`ifdef SAR_SAT_FLAG_EN
    .Result    (result2),
    .Sat       (sat2)
`else
    .Result    (result2)
`endif
  );

`ifndef SAR_SAT_FLAG_EN
  assign sat  = 1'b0;
  assign sat2 = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] vin;
    logic [9:0] expRes;
    logic [9:0] expSer;
    logic       expSat;
  } vec_t;

  vec_t vecs[6];

  int         doneCyc;
  logic [9:0] resCap;
  logic [9:0] serCap;
  logic       satCap;
  int         shiftCnt;
  int         shCnt;
  logic       busy1;
  logic       busyAtDone;
  logic [9:0] dacAtDone;
  logic [9:0] dacLog[64];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErr++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Runs one conversion from a Start pulse; cycle c is the c-th cycle after the Start edge.
  task automatic applyStimulus(input logic [9:0] vin, input bit extraStart);
    @(negedge clk);
    vinCode  = vin;
    start    = 1'b1;
    doneCyc  = 0;
    resCap   = '0;
    serCap   = '0;
    satCap   = 1'b0;
    shiftCnt = 0;
    shCnt    = 0;
    busy1    = 1'b0;
    for (int c = 1; c <= 60 && doneCyc == 0; c++) begin
      @(negedge clk);
      start = extraStart && (c == 5 || c == 15);
      dacLog[c] = dacCode;
      if (c == 1) busy1 = busy;
      if (sampleHold) shCnt++;
      if (shiftEn) begin
        serCap = {serCap[8:0], serOut};
        shiftCnt++;
      end
      if (done) begin
        doneCyc    = c;
        resCap     = result;
        satCap     = sat;
        busyAtDone = busy;
        dacAtDone  = dacCode;
      end
    end
    start = 1'b0;
  endtask

  int         doneAt[3];
  logic [9:0] resAt[3];
  int         doneCnt;
  logic       idle24;
  logic       idle48;
  logic       sh25;
  int         ones2;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    nErr     = 0;
    nChecks  = 0;
    clrN     = 1'b0;
    start    = 1'b0;
    vinCode  = '0;
    start2   = 1'b0;
    vinCode2 = '0;

    vecs[0] = '{10'h2A5, 10'h2A5, 10'b1010100101, 1'b0};
    vecs[1] = '{10'h000, 10'h000, 10'b0000000000, 1'b1};
    vecs[2] = '{10'h3FF, 10'h3FF, 10'b1111111111, 1'b1};
    vecs[3] = '{10'h200, 10'h200, 10'b1000000000, 1'b0};
    vecs[4] = '{10'h155, 10'h155, 10'b0101010101, 1'b0};
    vecs[5] = '{10'h0F0, 10'h0F0, 10'b0011110000, 1'b0};

    @(negedge clk);
    checkOutput("resetOutputs", {22'd0, sampleHold, dacCode, serOut, shiftEn, busy, done, sat},
                32'd0);
    checkOutput("resetResult", {22'd0, result}, 32'd0);
    @(negedge clk);
    clrN = 1'b1;
    @(negedge clk);
    checkOutput("idleBusy", {31'd0, busy}, 32'd0);

    for (int v = 0; v < 6; v++) begin
      applyStimulus(vecs[v].vin, 1'b0);
      checkOutput($sformatf("doneCycle[%0d]", v), doneCyc, 32'd23);
      checkOutput($sformatf("result[%0d]", v), {22'd0, resCap}, {22'd0, vecs[v].expRes});
      checkOutput($sformatf("sipo[%0d]", v), {22'd0, serCap}, {22'd0, vecs[v].expSer});
      checkOutput($sformatf("shiftCount[%0d]", v), shiftCnt, 32'd10);
      checkOutput($sformatf("sampleCycles[%0d]", v), shCnt, 32'd2);
      checkOutput($sformatf("busyCycle1[%0d]", v), {31'd0, busy1}, 32'd1);
      checkOutput($sformatf("doneBusyDac[%0d]", v), {21'd0, busyAtDone, dacAtDone}, 32'd0);
`ifdef SAR_SAT_FLAG_EN
      checkOutput($sformatf("sat[%0d]", v), {31'd0, satCap}, {31'd0, vecs[v].expSat});
`endif
      if (vecs[v].vin == 10'h000) begin
        for (int j = 0; j < 10; j++) begin
          checkOutput($sformatf("trialA[%0d]", j), {22'd0, dacLog[3 + 2 * j]}, 32'h200 >> j);
          checkOutput($sformatf("trialB[%0d]", j), {22'd0, dacLog[4 + 2 * j]}, 32'h200 >> j);
        end
      end
      repeat (2) @(negedge clk);
    end

    // Start re-pulsed while busy must not disturb the running conversion.
    applyStimulus(10'h2A5, 1'b1);
    checkOutput("busyStartDone", doneCyc, 32'd23);
    checkOutput("busyStartShifts", shiftCnt, 32'd10);
    checkOutput("busyStartResult", {22'd0, resCap}, 32'h2A5);
    repeat (3) @(negedge clk);
    checkOutput("busyStartNoRestart", {30'd0, busy, sampleHold}, 32'd0);

    // Start held high: back-to-back conversions with one IDLE cycle between them.
    @(negedge clk);
    vinCode = 10'h155;
    start   = 1'b1;
    doneCnt = 0;
    idle24  = 1'b1;
    idle48  = 1'b1;
    sh25    = 1'b0;
    for (int j = 0; j < 3; j++) begin
      doneAt[j] = 0;
      resAt[j]  = '0;
    end
    for (int c = 1; c <= 75; c++) begin
      @(negedge clk);
      if (done) begin
        if (doneCnt < 3) begin
          doneAt[doneCnt] = c;
          resAt[doneCnt]  = result;
        end
        doneCnt++;
      end
      if (c == 24) idle24 = busy | sampleHold;
      if (c == 48) idle48 = busy | sampleHold;
      if (c == 25) sh25 = sampleHold;
    end
    start = 1'b0;
    checkOutput("b2bDoneCount", doneCnt, 32'd3);
    for (int j = 0; j < 3; j++) begin
      checkOutput($sformatf("b2bDoneAt[%0d]", j), doneAt[j], 32'd23 + 32'(24 * j));
      checkOutput($sformatf("b2bResult[%0d]", j), {22'd0, resAt[j]}, 32'h155);
    end
    checkOutput("b2bIdle24", {31'd0, idle24}, 32'd0);
    checkOutput("b2bIdle48", {31'd0, idle48}, 32'd0);
    checkOutput("b2bSample25", {31'd0, sh25}, 32'd1);
    repeat (30) @(negedge clk);

    // Asynchronous reset after four bits have been decided.
    @(negedge clk);
    vinCode  = 10'h2A5;
    start    = 1'b1;
    shiftCnt = 0;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 40 && shiftCnt < 4; c++) begin
      if (shiftEn) shiftCnt++;
      if (shiftCnt < 4) @(negedge clk);
    end
    checkOutput("rstBitsBefore", shiftCnt, 32'd4);
    #2;
    clrN = 1'b0;
    #1;
    checkOutput("rstImmediate", {22'd0, sampleHold, dacCode, serOut, shiftEn, busy, done, sat},
                32'd0);
    checkOutput("rstResult", {22'd0, result}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    clrN     = 1'b1;
    shiftCnt = 0;
    doneCnt  = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (shiftEn) shiftCnt++;
      if (done) doneCnt++;
    end
    checkOutput("rstNoShift", shiftCnt, 32'd0);
    checkOutput("rstNoDone", doneCnt, 32'd0);
    checkOutput("rstResultHeld", {22'd0, result}, 32'd0);
    applyStimulus(10'h0F0, 1'b0);
    checkOutput("postRstDone", doneCyc, 32'd23);
    checkOutput("postRstResult", {22'd0, resCap}, 32'h0F0);
    checkOutput("postRstShifts", shiftCnt, 32'd10);

    // Slow-settle build: SAMPLE_CYC=1, SETTLE_CYC=3.
    @(negedge clk);
    vinCode2 = 10'h001;
    start2   = 1'b1;
    doneCyc  = 0;
    shiftCnt = 0;
    ones2    = 0;
    serCap   = '0;
    resCap   = '0;
    for (int c = 1; c <= 60 && doneCyc == 0; c++) begin
      @(negedge clk);
      start2 = 1'b0;
      if (shiftEn2) begin
        shiftCnt++;
        serCap = {serCap[8:0], serOut2};
        if (serOut2) ones2++;
      end
      if (done2) begin
        doneCyc = c;
        resCap  = result2;
      end
    end
    checkOutput("slowDone", doneCyc, 32'd32);
    checkOutput("slowResult", {22'd0, resCap}, 32'h001);
    checkOutput("slowShifts", shiftCnt, 32'd10);
    checkOutput("slowSerial", {22'd0, serCap}, 32'h001);
    checkOutput("slowOnes", ones2, 32'd1);

    $display("Result: errors=%0d of %0d checks", nErr, nChecks);
    $finish;
  end

endmodule
